// File: rtl/chan_mux_if.sv
// Channel-mux bus: parallel producer channels in, one registered valid/ready word out.
// Stats signals exist only when CHAN_MUX_STATS_EN is defined.
interface chan_mux_if #(
    parameter int unsigned NUM_CH = 6,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned SEL_W = $clog2(NUM_CH);

    logic [NUM_CH*DATA_W-1:0] d_in;
    logic [NUM_CH-1:0]        d_valid;
    logic [NUM_CH-1:0]        d_ready;
    logic                     mode;
    logic [SEL_W-1:0]         select;
    logic [DATA_W-1:0]        q;
    logic [SEL_W-1:0]         q_ch;
    logic                     q_valid;
    logic                     q_ready;
    logic                     sel_err;
`ifdef CHAN_MUX_STATS_EN
    logic [15:0]              xfer_cnt;
    logic [NUM_CH-1:0]        ch_busy;
`endif

    modport master (
        output d_in, d_valid, mode, select, q_ready,
`ifdef CHAN_MUX_STATS_EN
        input  xfer_cnt, ch_busy,
`endif
        input  d_ready, q, q_ch, q_valid, sel_err
    );

    modport slave (
        input  d_in, d_valid, mode, select, q_ready,
`ifdef CHAN_MUX_STATS_EN
        output xfer_cnt, ch_busy,
`endif
        output d_ready, q, q_ch, q_valid, sel_err
    );
endinterface

// File: rtl/chan_mux_reg.sv
// Registered N:1 channel mux, fixed-select or round-robin, with valid/ready output stage.
// Optional transfer/stall statistics when CHAN_MUX_STATS_EN is defined.
module chan_mux_reg #(
    parameter int unsigned NUM_CH = 6,
    parameter int unsigned DATA_W = 8
) (
    input logic       clk,
    input logic       rst_n,
    chan_mux_if.slave bus
);
    localparam int unsigned      SEL_W    = $clog2(NUM_CH);
    localparam logic [SEL_W:0]   NumChExt = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LastCh   = SEL_W'(NUM_CH - 1);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] q_q;
    logic [SEL_W-1:0]  q_ch_q;
    logic [SEL_W-1:0]  rr_ptr_q;
    logic              sel_err_q;

    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic              sel_bad, fix_gnt, rr_gnt, gnt_valid;
    logic [SEL_W-1:0]  rr_idx, gnt_idx;
    logic [SEL_W:0]    scan;
    logic              load_en, xfer;
    logic [NUM_CH-1:0] d_ready;
    logic              q_valid;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign ch_data[k] = bus.d_in[k*DATA_W +: DATA_W];
    end

    assign sel_bad = !bus.mode && ({1'b0, bus.select} >= NumChExt);
    assign fix_gnt = !bus.mode && !sel_bad && bus.d_valid[bus.select];

    // First valid channel at or after rr_ptr, wrapping at NUM_CH.
    always_comb begin
        rr_gnt = 1'b0;
        rr_idx = '0;
        scan   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            scan = {1'b0, rr_ptr_q} + (SEL_W+1)'(i);
            if (scan >= NumChExt) begin
                scan = scan - NumChExt;
            end
            if (!rr_gnt && bus.d_valid[scan[SEL_W-1:0]]) begin
                rr_gnt = 1'b1;
                rr_idx = scan[SEL_W-1:0];
            end
        end
    end

    assign gnt_valid = bus.mode ? rr_gnt : fix_gnt;
    assign gnt_idx   = bus.mode ? rr_idx : bus.select;
    // Reset gates load so no handshake completes in the reset cycle.
    assign load_en   = rst_n && (state_q == StEmpty || bus.q_ready);
    assign xfer      = load_en && gnt_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StEmpty: if (gnt_valid) state_d = StFull;
            StFull:  if (bus.q_ready) state_d = gnt_valid ? StFull : StEmpty;
        endcase
    end

    always_comb begin
        d_ready = '0;
        if (xfer) begin
            d_ready[gnt_idx] = 1'b1;
        end
        q_valid = (state_q == StFull);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q       <= '0;
            q_ch_q    <= '0;
            rr_ptr_q  <= '0;
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_bad;
            if (xfer) begin
                q_q      <= ch_data[gnt_idx];
                q_ch_q   <= gnt_idx;
                rr_ptr_q <= (gnt_idx == LastCh) ? '0 : gnt_idx + SEL_W'(1);
            end
        end
    end

    assign bus.d_ready = d_ready;
    assign bus.q_valid = q_valid;
    assign bus.q       = q_q;
    assign bus.q_ch    = q_ch_q;
    assign bus.sel_err = sel_err_q;

`ifdef CHAN_MUX_STATS_EN
    logic [15:0]       xfer_cnt_q;
    logic [NUM_CH-1:0] ch_busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_cnt_q <= '0;
            ch_busy_q  <= '0;
        end else begin
            if (q_valid && bus.q_ready && xfer_cnt_q != 16'hFFFF) begin
                xfer_cnt_q <= xfer_cnt_q + 16'd1;
            end
            ch_busy_q <= bus.d_valid & ~d_ready;
        end
    end

    assign bus.xfer_cnt = xfer_cnt_q;
    assign bus.ch_busy  = ch_busy_q;
`endif
endmodule

// File: tb/tb_chan_mux_reg.sv
// Randomized + directed bench for chan_mux_reg against a queue-free behavioural model.
// Exercises stats outputs as well when CHAN_MUX_STATS_EN is defined.
module tb_chan_mux_reg;
    localparam int NCH = 6;
    localparam logic [47:0] RrData = 48'h151413121110;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    // Model state
    logic [7:0] m_q;
    int         m_ch;
    bit         m_valid;
    int         m_ptr;
    bit         m_err;
    int         m_cnt;
    logic [5:0] m_busy;

    chan_mux_if #(.NUM_CH(NCH), .DATA_W(8)) bus ();

    chan_mux_reg #(.NUM_CH(NCH), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void find_grant(input bit md, input int sel, input logic [5:0] dv,
                                       output bit ok, output int g);
        ok = 1'b0;
        g  = 0;
        if (!md) begin
            if (sel < NCH && dv[sel]) begin
                ok = 1'b1;
                g  = sel;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!ok && dv[(m_ptr + i) % NCH]) begin
                    ok = 1'b1;
                    g  = (m_ptr + i) % NCH;
                end
            end
        end
    endfunction

    // One clock: apply inputs, check combinational ready, clock, advance model, check outputs.
    task automatic drive(input bit rst, input bit md, input int sel, input logic [5:0] dv,
                         input bit qr, input logic [47:0] din);
        bit         ok;
        int         g;
        logic [5:0] exp_rdy;
        @(negedge clk);
        rst_n       = rst;
        bus.mode    = md;
        bus.select  = 3'(sel);
        bus.d_valid = dv;
        bus.q_ready = qr;
        bus.d_in    = din;
        #1;
        find_grant(md, sel, dv, ok, g);
        exp_rdy = '0;
        if (rst && ok && (!m_valid || qr)) exp_rdy[g] = 1'b1;
        check_eq("d_ready", bus.d_ready, exp_rdy);
        @(posedge clk);
        if (!rst) begin
            m_q = '0; m_ch = 0; m_valid = 0; m_ptr = 0; m_err = 0; m_cnt = 0; m_busy = '0;
        end else begin
            if (m_valid && qr && m_cnt < 65535) m_cnt++;
            m_busy = dv & ~exp_rdy;
            m_err  = !md && sel >= NCH;
            if (!m_valid || qr) begin
                if (ok) begin
                    m_q     = din[g*8 +: 8];
                    m_ch    = g;
                    m_valid = 1'b1;
                    m_ptr   = (g + 1) % NCH;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        #1;
        check_eq("q", bus.q, m_q);
        check_eq("q_ch", bus.q_ch, m_ch);
        check_eq("q_valid", bus.q_valid, m_valid);
        check_eq("sel_err", bus.sel_err, m_err);
`ifdef CHAN_MUX_STATS_EN
        check_eq("xfer_cnt", bus.xfer_cnt, m_cnt);
        check_eq("ch_busy", bus.ch_busy, m_busy);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        m_q = '0; m_ch = 0; m_valid = 0; m_ptr = 0; m_err = 0; m_cnt = 0; m_busy = '0;

        // Reset held with every channel valid
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 6'h3F, 1, RrData);
            check_eq("rst_q_valid", bus.q_valid, 0);
            check_eq("rst_q", bus.q, 0);
        end
        drive(1, 1, 0, 6'h3F, 1, RrData);
        check_eq("rst_first_gnt", bus.q_ch, 0);

        // Fixed select of ch3
        drive(1, 0, 3, 6'b001000, 1, 48'h0000A5000000);
        check_eq("fix_q", bus.q, 8'hA5);
        check_eq("fix_ch", bus.q_ch, 3);
        check_eq("fix_valid", bus.q_valid, 1);

        // Round-robin from pointer 0
        drive(0, 1, 0, 6'h00, 1, RrData);
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, 6'h3F, 1, RrData);
            check_eq("rr_ch", bus.q_ch, i % NCH);
            check_eq("rr_q", bus.q, 8'h10 + (i % NCH));
        end

        // Backpressure holding q=8'h12, then no-bubble reload
        drive(0, 1, 0, 6'h00, 1, RrData);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 6'h3F, 1, RrData);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 6'h3F, 0, RrData);
            check_eq("bp_q", bus.q, 8'h12);
            check_eq("bp_ch", bus.q_ch, 2);
            check_eq("bp_valid", bus.q_valid, 1);
        end
        drive(1, 1, 0, 6'h3F, 1, RrData);
        check_eq("bp_reload_q", bus.q, 8'h13);
        check_eq("bp_reload_valid", bus.q_valid, 1);

        // Out-of-range select
        drive(1, 0, 6, 6'h3F, 0, RrData);
        check_eq("selerr_flag", bus.sel_err, 1);
        check_eq("selerr_held", bus.q_valid, 1);
        drive(1, 0, 7, 6'h3F, 1, RrData);
        check_eq("selerr_drain", bus.q_valid, 0);
        check_eq("selerr_flag7", bus.sel_err, 1);

        // Reset while a word is held
        drive(1, 1, 0, 6'h3F, 1, RrData);
        drive(1, 1, 0, 6'h3F, 0, RrData);
        drive(0, 1, 0, 6'h3F, 0, RrData);
        check_eq("midrst_valid", bus.q_valid, 0);
        drive(1, 1, 0, 6'h3F, 1, RrData);
        check_eq("midrst_ptr0", bus.q_ch, 0);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(63) != 0), 1'($urandom), int'($urandom_range(7)),
                  6'($urandom), ($urandom_range(3) != 0), {16'($urandom), 32'($urandom)});
        end

`ifdef CHAN_MUX_STATS_EN
        drive(0, 1, 0, 6'h3F, 1, RrData);
        check_eq("stats_rst_cnt", bus.xfer_cnt, 0);
        for (int i = 0; i < 70000; i++) drive(1, 1, 0, 6'h3F, 1, RrData);
        check_eq("stats_sat", bus.xfer_cnt, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
